// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch controller:
//   - fetch_state_e   : FSM state encoding (also exported on the debug port)
//   - NOP_INSTR_DEF   : word shown to decode after reset, on faults, after flush
//   - PC_INC_DEF      : default sequential PC increment in bytes
//   - TIMEOUT_CYCLES_DEF : default WAIT watchdog length (0 disables it)
//   - pc_add()        : 32-bit PC increment, wraps modulo 2^32
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF      = 32'h0000_0013;
  localparam int unsigned PC_INC_DEF         = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  function automatic logic [31:0] pc_add(input logic [31:0] pc, input int unsigned inc);
    logic [31:0] w_inc;
    w_inc = inc;
    return pc + w_inc;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// -----------------------------------------------------------------------------
// fetch_timeout_ctr
// Watchdog counter for the fetch WAIT state. Counts cycles while enabled and
// raises o_expired during the cycle in which the count equals
// TIMEOUT_CYCLES-1, i.e. the TIMEOUT_CYCLES-th enabled cycle after a clear.
// TIMEOUT_CYCLES = 0 removes the counter and ties o_expired low.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset (count -> 0)
//   i_clr      in   synchronous clear (wins over i_en)
//   i_en       in   count enable
//   o_expired  out  count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  // Only needs to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign o_expired = 1'b0;
    end else begin : g_enabled
      logic [CW-1:0] r_count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (i_clr) begin
          r_count <= '0;
        end else if (i_en) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign o_expired = (r_count == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
// Instruction-fetch controller between the PC register and decode. Issues one
// outstanding request at a time to instruction memory, buffers the returned
// word for decode, and drives the PC register write port (nwen/new_pc_value)
// for sequential advance and redirects.
//
// Build option: define FETCH_MISALIGN_EXC_EN to fault on a PC with
// pc_value[1:0] != 0 instead of fetching the aligned word.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both 1.
// imem_req_valid may be withdrawn before acceptance (a redirect drops it).
// imem_rsp_valid has no backpressure. On the decode side id_valid stays high
// and id_instr/id_pc/id_fault stay stable until id_ready is seen with it.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   pc_value        in  [31:0]     current PC from the PC register
//   new_pc_value    out [31:0]     value written to the PC register
//   nwen            out            PC register write enable, active low
//   imem_req_valid  out / imem_req_ready in / imem_addr out [31:0]
//   imem_rsp_valid  in  / imem_rsp_data in [31:0] / imem_rsp_err in
//   redirect_valid  in  / redirect_pc   in [31:0]
//   id_valid out / id_ready in / id_instr out [31:0] / id_pc out [31:0]
//   id_fault        out            bus error, timeout or misaligned fetch
//   dbg_state       out            current FSM state
// -----------------------------------------------------------------------------
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned PC_INC         = PC_INC_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_value,
  output logic [31:0]  new_pc_value,
  output logic         nwen,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  input  logic         imem_rsp_err,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         id_valid,
  input  logic         id_ready,
  output logic [31:0]  id_instr,
  output logic [31:0]  id_pc,
  output logic         id_fault,
  output fetch_state_e dbg_state
);

  fetch_state_e r_state, w_state_nxt;
  logic         r_id_valid, w_id_valid_nxt;
  logic         r_id_fault, w_id_fault_nxt;
  logic [31:0]  r_id_instr, w_id_instr_nxt;
  logic [31:0]  r_id_pc,    w_id_pc_nxt;
  logic [31:0]  r_req_pc,   w_req_pc_nxt;
  // Set when a redirect lands while a request is in flight: the response
  // that eventually comes back belongs to the old path and is dropped.
  logic         r_kill,     w_kill_nxt;
  logic         w_req_hs;
  logic         w_tmr_clr;
  logic         w_tmr_en;
  logic         w_tmr_expired;
  logic         w_misalign;

`ifdef FETCH_MISALIGN_EXC_EN
  assign w_misalign = (pc_value[1:0] != 2'b00);
  assign imem_addr  = pc_value;
`else
  // Low address bits are dropped; id_pc still reports the raw pc_value.
  assign w_misalign = 1'b0;
  assign imem_addr  = {pc_value[31:2], 2'b00};
`endif

  assign w_tmr_en = (r_state == ST_WAIT);

  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_id_valid <= 1'b0;
      r_id_fault <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= '0;
      r_req_pc   <= '0;
      r_kill     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_id_fault <= w_id_fault_nxt;
      r_id_instr <= w_id_instr_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_kill     <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_id_valid_nxt = r_id_valid;
    w_id_fault_nxt = r_id_fault;
    w_id_instr_nxt = r_id_instr;
    w_id_pc_nxt    = r_id_pc;
    w_req_pc_nxt   = r_req_pc;
    w_kill_nxt     = r_kill;
    w_req_hs       = 1'b0;
    w_tmr_clr      = 1'b0;
    nwen           = 1'b1;
    new_pc_value   = pc_value;
    imem_req_valid = 1'b0;

    if (r_id_valid && id_ready) begin
      w_id_valid_nxt = 1'b0;
    end

    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_REQ;
      end

      ST_REQ: begin
        if (w_misalign) begin
          w_id_valid_nxt = 1'b1;
          w_id_fault_nxt = 1'b1;
          w_id_instr_nxt = NOP_INSTR;
          w_id_pc_nxt    = pc_value;
          w_state_nxt    = ST_FAULT;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            w_req_hs     = 1'b1;
            w_req_pc_nxt = pc_value;
            w_tmr_clr    = 1'b1;
            w_state_nxt  = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (r_kill) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = ST_REQ;
          end else begin
            w_id_valid_nxt = 1'b1;
            w_id_fault_nxt = imem_rsp_err;
            w_id_instr_nxt = imem_rsp_data;
            w_id_pc_nxt    = r_req_pc;
            if (!imem_rsp_err) begin
              nwen         = 1'b0;
              new_pc_value = pc_add(r_req_pc, PC_INC);
              w_state_nxt  = ST_DRAIN;
            end else begin
              w_state_nxt  = ST_FAULT;
            end
          end
        end else if (w_tmr_expired) begin
          // A hung bus is reported even for a killed request: there is no
          // way to recover the transaction, so decode sees a fault.
          w_kill_nxt     = 1'b0;
          w_id_valid_nxt = 1'b1;
          w_id_fault_nxt = 1'b1;
          w_id_instr_nxt = NOP_INSTR;
          w_id_pc_nxt    = r_req_pc;
          w_state_nxt    = ST_FAULT;
        end
      end

      ST_DRAIN: begin
        if (!r_id_valid || id_ready) begin
          w_state_nxt = ST_REQ;
        end
      end

      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Redirect overrides everything above, including a sequential PC write.
    if (redirect_valid) begin
      nwen           = 1'b0;
      new_pc_value   = redirect_pc;
      w_id_valid_nxt = 1'b0;
      w_id_fault_nxt = 1'b0;
      w_id_instr_nxt = NOP_INSTR;
      w_id_pc_nxt    = r_id_pc;
      if ((r_state == ST_REQ) && w_req_hs) begin
        w_state_nxt = ST_WAIT;
        w_kill_nxt  = 1'b1;
      end else if ((r_state == ST_WAIT) && !imem_rsp_valid) begin
        // Give the orphaned request a fresh watchdog window.
        w_state_nxt = ST_WAIT;
        w_kill_nxt  = 1'b1;
        w_tmr_clr   = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
        w_kill_nxt  = 1'b0;
      end
    end
  end

  assign id_valid  = r_id_valid;
  assign id_fault  = r_id_fault;
  assign id_instr  = r_id_instr;
  assign id_pc     = r_id_pc;
  assign dbg_state = r_state;

endmodule
